dp_instr_encoder: RTL and testbench

//  Streaming encoder for ARM data-processing instructions. Takes decoded fields
//  (format, op, S, registers, shift/immediate) over valid/ready, checks legality with
//  the same rules the decode stage enforces, and emits the 32-bit word with a word

---
 rtl/dp_instr_encoder_if.sv | 40 ++++
 rtl/dp_instr_encoder.sv | 112 +++++++++++
 tb/tb_dp_instr_encoder.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dp_instr_encoder_if.sv
// Field-bundle / encoded-word bus between a program builder and dp_instr_encoder.
// The master side builds bundles and consumes words; the slave side is the encoder.
interface dp_instr_encoder_if #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned ERRCNT_W = 8
);
    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [1:0]          fmt;
    logic [3:0]          cond;
    logic [3:0]          op;
    logic                s;
    logic [3:0]          rn;
    logic [3:0]          rd;
    logic [3:0]          rs;
    logic [3:0]          rm;
    logic [4:0]          imm5;
    logic [1:0]          sh_type;
    logic [3:0]          rot;
    logic [7:0]          imm8;
    logic                out_valid;
    logic                out_ready;
    logic [31:0]         out_instr;
    logic [ADDR_W-1:0]   out_addr;
    logic                err;
    logic [ERRCNT_W-1:0] err_cnt;

    modport master (
        output flush, in_valid, fmt, cond, op, s, rn, rd, rs, rm, imm5, sh_type, rot, imm8,
        output out_ready,
        input  in_ready, out_valid, out_instr, out_addr, err, err_cnt
    );

    modport slave (
        input  flush, in_valid, fmt, cond, op, s, rn, rd, rs, rm, imm5, sh_type, rot, imm8,
        input  out_ready,
        output in_ready, out_valid, out_instr, out_addr, err, err_cnt
    );
endinterface

// File: rtl/dp_instr_encoder.sv
// Streaming ARM data-processing instruction encoder: legality check, one-deep output
// register with a word-address counter and a saturating illegal-bundle counter.
module dp_instr_encoder #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned ERRCNT_W  = 8
) (
    input logic              clk,
    input logic              rst,
    dp_instr_encoder_if.slave io_bus
);
    typedef enum logic {StEmpty, StFull} state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic [31:0]         r_instr;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_err;
    logic [ERRCNT_W-1:0] r_err_cnt;

    logic        w_in_ready;
    logic        w_accept;
    logic        w_legal;
    logic        w_is_cmp;
    logic        w_exc_ret;
    logic        w_fire;
    logic [31:0] w_enc;

    // Compare ops only make sense with S set; rd=pc is reserved for exception return.
    always_comb begin
        w_is_cmp  = (io_bus.op[3:2] == 2'b10);
        w_exc_ret = (io_bus.rd == 4'hF) && (io_bus.rn == 4'hE) && io_bus.s &&
                    ((io_bus.op == 4'hD) || (io_bus.op == 4'h2));
        w_legal   = (io_bus.fmt != 2'd3) &&
                    ((w_is_cmp && io_bus.s) || w_exc_ret ||
                     (!w_is_cmp && (io_bus.rd != 4'hF)));
    end

    always_comb begin
        w_enc = 32'h0;
        case (io_bus.fmt)
            2'd0: w_enc = {io_bus.cond, 3'b000, io_bus.op, io_bus.s, io_bus.rn, io_bus.rd,
                           io_bus.imm5, io_bus.sh_type, 1'b0, io_bus.rm};
            2'd1: w_enc = {io_bus.cond, 3'b000, io_bus.op, io_bus.s, io_bus.rn, io_bus.rd,
                           io_bus.rs, 1'b0, io_bus.sh_type, 1'b1, io_bus.rm};
            2'd2: w_enc = {io_bus.cond, 3'b001, io_bus.op, io_bus.s, io_bus.rn, io_bus.rd,
                           io_bus.rot, io_bus.imm8};
            default: w_enc = 32'h0;
        endcase
    end

    assign w_in_ready = ((r_state == StEmpty) || io_bus.out_ready) && !io_bus.flush;
    assign w_accept   = io_bus.in_valid && w_in_ready;
    assign w_fire     = (r_state == StFull) && io_bus.out_ready;

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StEmpty;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
        if (io_bus.flush) begin
            w_state_next = StEmpty;
        end else if (w_accept && w_legal) begin
            w_state_next = StFull;
        end else if (w_fire) begin
            w_state_next = StEmpty;
        end
    end

    // FSM: outputs
    always_comb begin
        io_bus.in_ready  = w_in_ready;
        io_bus.out_valid = (r_state == StFull);
        io_bus.out_instr = r_instr;
        io_bus.out_addr  = r_addr;
        io_bus.err       = r_err;
        io_bus.err_cnt   = r_err_cnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr   <= 32'h0;
            r_addr    <= ADDR_W'(BASE_ADDR);
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else if (io_bus.flush) begin
            r_instr   <= 32'h0;
            r_addr    <= ADDR_W'(BASE_ADDR);
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            if (w_accept && w_legal) begin
                r_instr <= w_enc;
            end
            // Address names the word currently held, so it advances only once consumed.
            if (w_fire) begin
                r_addr <= r_addr + ADDR_W'(1);
            end
            r_err <= w_accept && !w_legal;
            if (w_accept && !w_legal && (r_err_cnt != {ERRCNT_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + ERRCNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_dp_instr_encoder.sv
// Directed self-checking bench for dp_instr_encoder; inputs change and outputs are
// sampled on the falling clock edge.
module tb_dp_instr_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    dp_instr_encoder_if #(.ADDR_W(8), .ERRCNT_W(8)) bus ();

    dp_instr_encoder #(.ADDR_W(8), .BASE_ADDR(0), .ERRCNT_W(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus.slave)
    );

    task automatic drive(input logic [1:0] f, input logic [3:0] c, input logic [3:0] o,
                         input logic sf, input logic [3:0] n, input logic [3:0] d,
                         input logic [3:0] rsv, input logic [3:0] m, input logic [4:0] i5,
                         input logic [1:0] sh, input logic [3:0] rt, input logic [7:0] i8);
        bus.fmt = f; bus.cond = c; bus.op = o; bus.s = sf; bus.rn = n; bus.rd = d;
        bus.rs = rsv; bus.rm = m; bus.imm5 = i5; bus.sh_type = sh; bus.rot = rt;
        bus.imm8 = i8; bus.in_valid = 1'b1;
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.flush = 1'b0;
        drive(2'd0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 5'h0, 2'd0, 4'h0, 8'h0);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'h0 || bus.out_addr !== 8'h0 ||
            bus.err !== 1'b0 || bus.err_cnt !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b instr=%h addr=%h err=%b cnt=%h, want 0s",
                     bus.out_valid, bus.out_instr, bus.out_addr, bus.err, bus.err_cnt);
        end
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_dp0();
        do_reset();
        // ADD r1,r2,r3
        drive(2'd0, 4'hE, 4'h4, 1'b0, 4'h2, 4'h1, 4'h0, 4'h3, 5'h0, 2'd0, 4'h0, 8'h0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'hE0821003 || bus.out_addr !== 8'h0)
        begin
            n_fail++;
            $display("FAIL dp0_add: valid=%b instr=%h addr=%h want 1 E0821003 00",
                     bus.out_valid, bus.out_instr, bus.out_addr);
        end
        // MOV r5,r6,ASR #31 with rs=7 which DP0 must ignore
        bus.out_ready = 1'b1;
        drive(2'd0, 4'hE, 4'hD, 1'b0, 4'h0, 4'h5, 4'h7, 4'h6, 5'd31, 2'd2, 4'h0, 8'h0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_tests++;
        if (bus.out_instr !== 32'hE1A05FC6 || bus.out_addr !== 8'h1) begin
            n_fail++;
            $display("FAIL dp0_mov_asr: instr=%h addr=%h want E1A05FC6 01",
                     bus.out_instr, bus.out_addr);
        end
        // DP2 ADD r1,r2,#0x3F ror 28, cond EQ
        drive(2'd2, 4'h0, 4'h4, 1'b0, 4'h2, 4'h1, 4'h0, 4'h0, 5'h0, 2'd0, 4'hE, 8'h3F);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_tests++;
        if (bus.out_instr !== 32'h02821E3F || bus.out_addr !== 8'h2) begin
            n_fail++;
            $display("FAIL dp2_rot: instr=%h addr=%h want 02821E3F 02",
                     bus.out_instr, bus.out_addr);
        end
        @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.out_addr !== 8'h3) begin
            n_fail++;
            $display("FAIL dp0_drain: valid=%b addr=%h want 0 03", bus.out_valid, bus.out_addr);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.out_ready = 1'b1;
        drive(2'd1, 4'hE, 4'h4, 1'b0, 4'h2, 4'h1, 4'h4, 4'h3, 5'h0, 2'd0, 4'h0, 8'h0);
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready0: got %b want 1", bus.in_ready);
        end
        @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'hE0821413 || bus.out_addr !== 8'h0 ||
            bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_dp1: valid=%b instr=%h addr=%h rdy=%b want 1 E0821413 00 1",
                     bus.out_valid, bus.out_instr, bus.out_addr, bus.in_ready);
        end
        drive(2'd2, 4'hE, 4'hD, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 5'h0, 2'd0, 4'h0, 8'hFF);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'hE3A000FF || bus.out_addr !== 8'h1 ||
            bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_dp2: valid=%b instr=%h addr=%h rdy=%b want 1 E3A000FF 01 1",
                     bus.out_valid, bus.out_instr, bus.out_addr, bus.in_ready);
        end
        @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_empty: valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_exc_return();
        do_reset();
        bus.out_ready = 1'b1;
        // MOVS pc,lr
        drive(2'd0, 4'hE, 4'hD, 1'b1, 4'hE, 4'hF, 4'h0, 4'hE, 5'h0, 2'd0, 4'h0, 8'h0);
        @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'hE1BEF00E) begin
            n_fail++;
            $display("FAIL movs_pc_lr: valid=%b instr=%h want 1 E1BEF00E",
                     bus.out_valid, bus.out_instr);
        end
        // ADD pc,r2,r3 is illegal
        drive(2'd0, 4'hE, 4'h4, 1'b0, 4'h2, 4'hF, 4'h0, 4'h3, 5'h0, 2'd0, 4'h0, 8'h0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_tests++;
        if (bus.err !== 1'b1 || bus.out_valid !== 1'b0 || bus.err_cnt !== 8'd1 ||
            bus.out_addr !== 8'h1) begin
            n_fail++;
            $display("FAIL add_rd15: err=%b valid=%b cnt=%0d addr=%h want 1 0 1 01",
                     bus.err, bus.out_valid, bus.err_cnt, bus.out_addr);
        end
        @(negedge clk);
        n_tests++;
        if (bus.err !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL err_pulse: err=%b valid=%b want 0 0", bus.err, bus.out_valid);
        end
    endtask

    task automatic test_cmp();
        do_reset();
        bus.out_ready = 1'b1;
        drive(2'd0, 4'hE, 4'hA, 1'b0, 4'h1, 4'h0, 4'h0, 4'h2, 5'h0, 2'd0, 4'h0, 8'h0);
        @(negedge clk);
        n_tests++;
        if (bus.err !== 1'b1 || bus.err_cnt !== 8'd1 || bus.out_addr !== 8'h0 ||
            bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL cmp_s0: err=%b cnt=%0d addr=%h valid=%b want 1 1 00 0",
                     bus.err, bus.err_cnt, bus.out_addr, bus.out_valid);
        end
        bus.s = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'hE1510002 || bus.out_addr !== 8'h0 ||
            bus.err !== 1'b0 || bus.err_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL cmp_s1: valid=%b instr=%h addr=%h err=%b cnt=%0d want 1 E1510002 00 0 1",
                     bus.out_valid, bus.out_instr, bus.out_addr, bus.err, bus.err_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_stall_flush();
        do_reset();
        bus.out_ready = 1'b1;
        drive(2'd0, 4'hE, 4'h4, 1'b0, 4'h2, 4'h1, 4'h0, 4'h3, 5'h0, 2'd0, 4'h0, 8'h0);
        @(negedge clk);
        drive(2'd3, 4'hE, 4'h4, 1'b0, 4'h2, 4'h1, 4'h0, 4'h3, 5'h0, 2'd0, 4'h0, 8'h0);
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(2'd0, 4'hE, 4'h4, 1'b0, 4'h2, 4'h1, 4'h0, 4'h3, 5'h0, 2'd0, 4'h0, 8'h0);
        @(negedge clk);
        drive(2'd2, 4'hE, 4'hD, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 5'h0, 2'd0, 4'h0, 8'h11);
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'hE0821003 ||
                bus.out_addr !== 8'h1 || bus.in_ready !== 1'b0 || bus.err_cnt !== 8'd1) begin
                n_fail++;
                $display("FAIL stall_%0d: valid=%b instr=%h addr=%h rdy=%b cnt=%0d want 1 E0821003 01 0 1",
                         i, bus.out_valid, bus.out_instr, bus.out_addr, bus.in_ready, bus.err_cnt);
            end
            @(negedge clk);
        end
        bus.flush = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_in_ready: got %b want 0", bus.in_ready);
        end
        @(negedge clk);
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.out_addr !== 8'h0 || bus.err_cnt !== 8'd0 ||
            bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL flush: valid=%b addr=%h cnt=%0d err=%b want 0 00 0 0",
                     bus.out_valid, bus.out_addr, bus.err_cnt, bus.err);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(2'd0, 4'hE, 4'h4, 1'b0, 4'h2, 4'h1, 4'h0, 4'h3, 5'h0, 2'd0, 4'h0, 8'h0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'h0 || bus.out_addr !== 8'h0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b instr=%h addr=%h want 0 0 00",
                     bus.out_valid, bus.out_instr, bus.out_addr);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_wrap_saturate();
        do_reset();
        bus.out_ready = 1'b1;
        drive(2'd0, 4'hE, 4'h4, 1'b0, 4'h2, 4'h0, 4'h0, 4'h3, 5'h0, 2'd0, 4'h0, 8'h0);
        for (int k = 1; k <= 257; k++) begin
            @(negedge clk);
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_addr !== 8'((k - 1) % 256)) begin
                n_fail++;
                $display("FAIL wrap_%0d: valid=%b addr=%h want 1 %h",
                         k, bus.out_valid, bus.out_addr, 8'((k - 1) % 256));
            end
            bus.rd = 4'(k % 15);
        end
        // Stream illegal bundles to saturate the error counter
        drive(2'd3, 4'hE, 4'h4, 1'b0, 4'h2, 4'h1, 4'h0, 4'h3, 5'h0, 2'd0, 4'h0, 8'h0);
        for (int j = 1; j <= 257; j++) begin
            @(negedge clk);
            n_tests++;
            if (bus.err !== 1'b1 || bus.err_cnt !== 8'((j > 255) ? 255 : j)) begin
                n_fail++;
                $display("FAIL sat_%0d: err=%b cnt=%0d want 1 %0d",
                         j, bus.err, bus.err_cnt, (j > 255) ? 255 : j);
            end
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.out_addr !== 8'h1 || bus.err_cnt !== 8'd255 ||
            bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_end: valid=%b addr=%h cnt=%0d err=%b want 0 01 255 0",
                     bus.out_valid, bus.out_addr, bus.err_cnt, bus.err);
        end
    endtask

    initial begin
        test_reset();
        test_dp0();
        test_back_to_back();
        test_exc_return();
        test_cmp();
        test_stall_flush();
        test_async_reset();
        test_wrap_saturate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
